// File: rtl/rca_share_ctrl.sv
// Two-requester round-robin sequencer for one shared external 4-bit ripple-carry adder slice.
// Operands are added nibble-serially, LSB first, with the inter-slice carry held in a register.
//
// state | meaning
// IDLE  | arbitrate req0/req1, latch winner operands on grant
// RUN   | drive one nibble per cycle to the shared adder, capture its sum/carry
// DONE  | one-cycle result-valid pulse; requests are not sampled
module rca_share_ctrl #(
   parameter int OP_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0,
   input  logic [OP_W-1:0] a0,
   input  logic [OP_W-1:0] b0,
   input  logic            cin0,
   input  logic            req1,
   input  logic [OP_W-1:0] a1,
   input  logic [OP_W-1:0] b1,
   input  logic            cin1,
   output logic            gnt0,
   output logic            gnt1,
   output logic [3:0]      add_a,
   output logic [3:0]      add_b,
   output logic            add_cin,
   input  logic [3:0]      add_s,
   input  logic            add_cout,
   output logic            busy,
   output logic            done,
   output logic            done_id,
   output logic [OP_W-1:0] sum,
   output logic            cout,
   output logic            ovf
);

   localparam int NSLICE = OP_W / 4;
   localparam int IW = (NSLICE > 2) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [OP_W-1:0] a_lat, b_lat;
   logic [OP_W-1:0] sum_sh, sum_nxt;
   logic            owner, last_id;
   logic            grant, win;
   logic            run, last_slice;
   logic [IW+1:0]   nib;

   assign run        = (state == RUN);
   assign last_slice = run && (idx == LAST_IDX);
   assign nib        = {idx, 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      win       = 1'b0;
      case (state)
         IDLE: begin
            // tie goes to whoever was not served last
            if (req0 && (!req1 || last_id)) begin
               grant     = 1'b1;
               win       = 1'b0;
               state_nxt = RUN;
            end else if (req1) begin
               grant     = 1'b1;
               win       = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN:     if (idx == LAST_IDX) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum_nxt           = sum_sh;
      sum_nxt[nib +: 4] = add_s;
   end

   assign add_a   = run ? a_lat[nib +: 4] : 4'd0;
   assign add_b   = run ? b_lat[nib +: 4] : 4'd0;
   assign add_cin = run ? carry : 1'b0;
   assign busy    = (state == RUN) || (state == DONE);
   assign done    = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx     <= '0;
         carry   <= 1'b0;
         a_lat   <= '0;
         b_lat   <= '0;
         sum_sh  <= '0;
         owner   <= 1'b0;
         last_id <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done_id <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         gnt0 <= grant && !win;
         gnt1 <= grant && win;
         if (grant) begin
            a_lat   <= win ? a1 : a0;
            b_lat   <= win ? b1 : b0;
            carry   <= win ? cin1 : cin0;
            idx     <= '0;
            last_id <= win;
            owner   <= win;
         end
         if (run) begin
            sum_sh <= sum_nxt;
            carry  <= add_cout;
            idx    <= idx + 1'b1;
         end
         // visible result only moves at the completion edge
         if (last_slice) begin
            sum     <= sum_nxt;
            cout    <= add_cout;
            ovf     <= (a_lat[OP_W-1] == b_lat[OP_W-1]) && (add_s[3] != a_lat[OP_W-1]);
            done_id <= owner;
         end
      end
   end

endmodule
